// File: rtl/block_memory.sv
// block_memory: word-addressed main memory behind the direct-mapped cache.
// Serves 4-word block fills (word 0 first) and two-phase (address, data)
// writes on a shared 16-bit bus; a write with rrqst also high is a
// write-miss and is followed by a fill with no rrdy pulse.
//
// Parameters:
//   ADDR_W    word-address width, array holds 2^ADDR_W 16-bit words
//   READ_LAT  idle cycles between address capture and the read reply (0..15)
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high; clears FSM and outputs, not the array
//   macc       cache access active; low aborts back to IDLE
//   rrqst      block fill request
//   wrqst      write request (1st: address, 2nd: data)
//   rdacpt     cache has taken the current read word
//   bus_in     address or write data
//   rrdy       read accepted, one-cycle pulse
//   rdrdy      read word valid on bus_out
//   wacpt      write phase accepted
//   bus_out    read word
//   bus_oe     bus_out drive enable (equals rdrdy)
//   rd_bursts  completed read bursts
//   wr_count   committed writes
//
// Build option MEM_STATS_EN: when defined, rd_bursts and wr_count are
// 16-bit saturating counters; otherwise both are tied to zero.

module block_memory #(
   parameter int ADDR_W   = 16,
   parameter int READ_LAT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        macc,
   input  logic        rrqst,
   input  logic        wrqst,
   input  logic        rdacpt,
   input  logic [15:0] bus_in,
   output logic        rrdy,
   output logic        rdrdy,
   output logic        wacpt,
   output logic [15:0] bus_out,
   output logic        bus_oe,
   output logic [15:0] rd_bursts,
   output logic [15:0] wr_count
);

   typedef enum logic [2:0] {
      IDLE,
      RD_LAT,
      RD_RDY,
      RD_SEND,
      RD_REL,
      WA_ACK,
      WD_WAIT,
      WD_ACK
   } state_t;

   localparam int         BW  = ADDR_W - 2;
   localparam logic [3:0] LAT = 4'(READ_LAT);

   logic [15:0] mem [0:(1 << ADDR_W) - 1];

   state_t        state, state_n;
   logic [BW-1:0] base, base_n;
   logic [1:0]    off, off_n;
   logic [1:0]    word, word_n;
   logic [3:0]    cnt, cnt_n;
   logic          rd_pend, rd_pend_n;
   logic          rrdy_n, rdrdy_n, wacpt_n;

   logic              ld_word;
   logic              mem_we;
   logic              burst_done;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;

   assign wr_addr = {base, off};
   assign bus_oe  = rdrdy;

   // Next-state and next-output logic; outputs are registered below.
   always_comb begin
      state_n    = state;
      base_n     = base;
      off_n      = off;
      word_n     = word;
      cnt_n      = cnt;
      rd_pend_n  = rd_pend;
      rrdy_n     = 1'b0;
      rdrdy_n    = 1'b0;
      wacpt_n    = 1'b0;
      ld_word    = 1'b0;
      mem_we     = 1'b0;
      burst_done = 1'b0;
      rd_addr    = {base, word};

      if (!macc) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (wrqst) begin
                  // Write wins; rrqst alongside marks a write-miss.
                  base_n    = bus_in[ADDR_W-1:2];
                  off_n     = bus_in[1:0];
                  rd_pend_n = rrqst;
                  wacpt_n   = 1'b1;
                  state_n   = WA_ACK;
               end else if (rrqst) begin
                  base_n    = bus_in[ADDR_W-1:2];
                  rd_pend_n = 1'b0;
                  word_n    = 2'd0;
                  cnt_n     = 4'd0;
                  state_n   = RD_LAT;
               end
            end
            RD_LAT: begin
               if (cnt == LAT) begin
                  if (rd_pend) begin
                     // Cache already waits on rdrdy after a write-miss.
                     rd_addr = {base, 2'd0};
                     ld_word = 1'b1;
                     rdrdy_n = 1'b1;
                     state_n = RD_SEND;
                  end else begin
                     rrdy_n  = 1'b1;
                     state_n = RD_RDY;
                  end
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
            RD_RDY: begin
               word_n  = 2'd0;
               rd_addr = {base, 2'd0};
               ld_word = 1'b1;
               rdrdy_n = 1'b1;
               state_n = RD_SEND;
            end
            RD_SEND: begin
               if (rdacpt) begin
                  state_n = RD_REL;
               end else begin
                  rdrdy_n = 1'b1;
               end
            end
            RD_REL: begin
               if (!rdacpt) begin
                  if (word == 2'd3) begin
                     burst_done = 1'b1;
                     state_n    = IDLE;
                  end else begin
                     word_n  = word + 2'd1;
                     rd_addr = {base, word + 2'd1};
                     ld_word = 1'b1;
                     rdrdy_n = 1'b1;
                     state_n = RD_SEND;
                  end
               end
            end
            WA_ACK: begin
               if (wrqst) begin
                  wacpt_n = 1'b1;
               end else begin
                  state_n = WD_WAIT;
               end
            end
            WD_WAIT: begin
               if (wrqst) begin
                  mem_we  = 1'b1;
                  wacpt_n = 1'b1;
                  state_n = WD_ACK;
               end
            end
            WD_ACK: begin
               if (wrqst) begin
                  wacpt_n = 1'b1;
               end else if (rd_pend) begin
                  word_n  = 2'd0;
                  cnt_n   = 4'd0;
                  state_n = RD_LAT;
               end else begin
                  state_n = IDLE;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         base    <= '0;
         off     <= 2'd0;
         word    <= 2'd0;
         cnt     <= 4'd0;
         rd_pend <= 1'b0;
         rrdy    <= 1'b0;
         rdrdy   <= 1'b0;
         wacpt   <= 1'b0;
         bus_out <= 16'd0;
      end else begin
         state   <= state_n;
         base    <= base_n;
         off     <= off_n;
         word    <= word_n;
         cnt     <= cnt_n;
         rd_pend <= rd_pend_n;
         rrdy    <= rrdy_n;
         rdrdy   <= rdrdy_n;
         wacpt   <= wacpt_n;
         // Hold the word while rdrdy stays high; drive zero otherwise.
         if (ld_word) begin
            bus_out <= mem[rd_addr];
         end else if (!rdrdy_n) begin
            bus_out <= 16'd0;
         end
      end
   end

   // Array has no reset; a write pending at reset is dropped.
   always_ff @(posedge clock) begin
      if (mem_we && !reset) begin
         mem[wr_addr] <= bus_in;
      end
   end

`ifdef MEM_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_bursts <= 16'd0;
         wr_count  <= 16'd0;
      end else begin
         if (burst_done && (rd_bursts != 16'hFFFF)) begin
            rd_bursts <= rd_bursts + 16'd1;
         end
         if (mem_we && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end
`else
   logic unused_stats;
   assign unused_stats = burst_done;
   assign rd_bursts    = 16'd0;
   assign wr_count     = 16'd0;
`endif

endmodule

// File: tb/tb_block_memory.sv
// tb_block_memory: scoreboard bench for block_memory.
// Expected read words come from a bench-side model of written data.

module tb_block_memory;

   localparam int READ_LAT = 4;
`ifdef MEM_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        macc;
   logic        rrqst;
   logic        wrqst;
   logic        rdacpt;
   logic [15:0] bus_in;
   logic        rrdy;
   logic        rdrdy;
   logic        wacpt;
   logic [15:0] bus_out;
   logic        bus_oe;
   logic [15:0] rd_bursts;
   logic [15:0] wr_count;

   int checks = 0;
   int errors = 0;
   int exp_rb = 0;
   int exp_wr = 0;
   int rrdy_cnt = 0;
   int rdrdy_cnt = 0;

   logic [15:0] model [logic [15:0]];
   logic [15:0] sb [$];

   block_memory #(
      .ADDR_W   (16),
      .READ_LAT (READ_LAT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .macc      (macc),
      .rrqst     (rrqst),
      .wrqst     (wrqst),
      .rdacpt    (rdacpt),
      .bus_in    (bus_in),
      .rrdy      (rrdy),
      .rdrdy     (rdrdy),
      .wacpt     (wacpt),
      .bus_out   (bus_out),
      .bus_oe    (bus_oe),
      .rd_bursts (rd_bursts),
      .wr_count  (wr_count)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (rrdy === 1'b1) rrdy_cnt++;
      if (rdrdy === 1'b1) rdrdy_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish, got running want finished");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic wait_wacpt(input logic v);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (wacpt !== v && n < 20);
      checks++;
      if (wacpt !== v) begin
         errors++;
         $display("FAIL wacpt_wait: got %b want %b", wacpt, v);
      end
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] d);
      bus_in = a;
      wrqst  = 1'b1;
      wait_wacpt(1'b1);
      wrqst = 1'b0;
      wait_wacpt(1'b0);
      bus_in = d;
      wrqst  = 1'b1;
      wait_wacpt(1'b1);
      model[a] = d;
      exp_wr += STATS;
      wrqst  = 1'b0;
      bus_in = 16'd0;
      wait_wacpt(1'b0);
   endtask

   task automatic push_block(input logic [15:0] a);
      logic [15:0] ad;
      for (int w = 0; w < 4; w++) begin
         ad = (a & 16'hFFFC) | 16'(w);
         sb.push_back(model[ad]);
      end
   endtask

   task automatic start_read(input logic [15:0] a);
      bus_in = a;
      rrqst  = 1'b1;
      tick();
      rrqst  = 1'b0;
      bus_in = 16'd0;
      push_block(a);
   endtask

   task automatic recv_word(input int hold);
      int n;
      logic [15:0] first;
      logic [15:0] exp;
      n = 0;
      while (rdrdy !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (rdrdy !== 1'b1) begin
         errors++;
         $display("FAIL rdrdy_wait: got %b want 1", rdrdy);
         return;
      end
      first = bus_out;
      for (int i = 0; i < hold; i++) begin
         tick();
         checks++;
         if (rdrdy !== 1'b1 || bus_out !== first) begin
            errors++;
            $display("FAIL hold_stable: got rdrdy=%b bus=%h want 1 %h",
                     rdrdy, bus_out, first);
         end
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL sb_empty: got word %h want none", bus_out);
      end else begin
         exp = sb.pop_front();
         if (bus_out !== exp || bus_oe !== 1'b1) begin
            errors++;
            $display("FAIL read_word: got %h oe=%b want %h oe=1",
                     bus_out, bus_oe, exp);
         end
      end
      rdacpt = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (rdrdy !== 1'b0 && n < 40);
      rdacpt = 1'b0;
   endtask

   task automatic test_reset;
      reset  = 1'b1;
      macc   = 1'b1;
      rrqst  = 1'b0;
      wrqst  = 1'b0;
      rdacpt = 1'b0;
      bus_in = 16'd0;
      tick();
      tick();
      checks++;
      if ({rrdy, rdrdy, wacpt, bus_oe} !== 4'b0 || bus_out !== 16'd0 ||
          rd_bursts !== 16'd0 || wr_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b%b%b%b %h %h %h want all 0",
                  rrdy, rdrdy, wacpt, bus_oe, bus_out, rd_bursts, wr_count);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_plain_write;
      int rd0;
      do_write(16'h0040, 16'h1111);
      do_write(16'h0042, 16'h3333);
      do_write(16'h0043, 16'h4444);
      rd0 = rdrdy_cnt;
      bus_in = 16'h0041;
      wrqst  = 1'b1;
      tick();
      checks++;
      if (wacpt !== 1'b1) begin
         errors++;
         $display("FAIL wacpt_addr_rise: got %b want 1", wacpt);
      end
      wrqst = 1'b0;
      tick();
      checks++;
      if (wacpt !== 1'b0) begin
         errors++;
         $display("FAIL wacpt_addr_fall: got %b want 0", wacpt);
      end
      bus_in = 16'hBEEF;
      wrqst  = 1'b1;
      tick();
      checks++;
      if (wacpt !== 1'b1) begin
         errors++;
         $display("FAIL wacpt_data_rise: got %b want 1", wacpt);
      end
      model[16'h0041] = 16'hBEEF;
      exp_wr += STATS;
      wrqst  = 1'b0;
      bus_in = 16'd0;
      tick();
      checks++;
      if (wacpt !== 1'b0) begin
         errors++;
         $display("FAIL wacpt_data_fall: got %b want 0", wacpt);
      end
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (rdrdy_cnt != rd0 || wr_count !== 16'(exp_wr)) begin
         errors++;
         $display("FAIL plain_write_side: got rdrdy_cyc=%0d wr=%0d want %0d %0d",
                  rdrdy_cnt - rd0, wr_count, 0, exp_wr);
      end
      start_read(16'h0040);
      for (int w = 0; w < 4; w++) recv_word(0);
      exp_rb += STATS;
   endtask

   task automatic test_block_read;
      int c;
      int rrdy_c;
      int rdrdy_c;
      do_write(16'h0041, 16'h2222);
      bus_in = 16'h0042;
      rrqst  = 1'b1;
      tick();
      rrqst  = 1'b0;
      bus_in = 16'd0;
      c       = 0;
      rrdy_c  = -1;
      rdrdy_c = -1;
      while (c < 30) begin
         tick();
         c++;
         if (rrdy === 1'b1 && rrdy_c < 0) rrdy_c = c;
         if (rdrdy === 1'b1) begin
            rdrdy_c = c;
            break;
         end
      end
      checks++;
      if (rrdy_c != READ_LAT + 1 || rdrdy_c != READ_LAT + 2 ||
          rrdy !== 1'b0) begin
         errors++;
         $display("FAIL read_timing: got rrdy@%0d rdrdy@%0d want %0d %0d",
                  rrdy_c, rdrdy_c, READ_LAT + 1, READ_LAT + 2);
      end
      push_block(16'h0042);
      for (int w = 0; w < 4; w++) recv_word(0);
      exp_rb += STATS;
      tick();
      checks++;
      if (rd_bursts !== 16'(exp_rb)) begin
         errors++;
         $display("FAIL rd_bursts_read: got %0d want %0d", rd_bursts, exp_rb);
      end
   endtask

   task automatic test_write_miss;
      int r0;
      int n;
      do_write(16'h0080, 16'h8000);
      do_write(16'h0082, 16'h8222);
      do_write(16'h0083, 16'h8333);
      r0 = rrdy_cnt;
      bus_in = 16'h0081;
      wrqst  = 1'b1;
      rrqst  = 1'b1;
      tick();
      wrqst = 1'b0;
      rrqst = 1'b0;
      tick();
      bus_in = 16'hA5A5;
      wrqst  = 1'b1;
      tick();
      model[16'h0081] = 16'hA5A5;
      exp_wr += STATS;
      wrqst  = 1'b0;
      bus_in = 16'd0;
      tick();
      checks++;
      if (wacpt !== 1'b0) begin
         errors++;
         $display("FAIL miss_wacpt_fall: got %b want 0", wacpt);
      end
      n = 0;
      while (rdrdy !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      checks++;
      if (n != READ_LAT + 1) begin
         errors++;
         $display("FAIL miss_fill_lat: got %0d want %0d", n, READ_LAT + 1);
      end
      push_block(16'h0081);
      for (int w = 0; w < 4; w++) recv_word(0);
      exp_rb += STATS;
      tick();
      checks++;
      if (rrdy_cnt != r0 || rd_bursts !== 16'(exp_rb) ||
          wr_count !== 16'(exp_wr)) begin
         errors++;
         $display("FAIL miss_side: got rrdy=%0d rb=%0d wr=%0d want 0 %0d %0d",
                  rrdy_cnt - r0, rd_bursts, wr_count, exp_rb, exp_wr);
      end
   endtask

   task automatic test_slow_acceptor;
      start_read(16'h0043);
      recv_word(0);
      recv_word(0);
      recv_word(7);
      recv_word(0);
      exp_rb += STATS;
      tick();
      checks++;
      if (sb.size() != 0 || rd_bursts !== 16'(exp_rb)) begin
         errors++;
         $display("FAIL slow_done: got left=%0d rb=%0d want 0 %0d",
                  sb.size(), rd_bursts, exp_rb);
      end
   endtask

   task automatic test_abort;
      start_read(16'h0080);
      recv_word(0);
      recv_word(0);
      macc = 1'b0;
      tick();
      checks++;
      if ({rrdy, rdrdy, wacpt, bus_oe} !== 4'b0 || bus_out !== 16'd0 ||
          rd_bursts !== 16'(exp_rb)) begin
         errors++;
         $display("FAIL abort_outputs: got %b%b%b%b %h rb=%0d want 0 0 %0d",
                  rrdy, rdrdy, wacpt, bus_oe, bus_out, rd_bursts, exp_rb);
      end
      sb.delete();
      tick();
      macc = 1'b1;
      tick();
      start_read(16'h0040);
      for (int w = 0; w < 4; w++) recv_word(0);
      exp_rb += STATS;
      tick();
      checks++;
      if (rd_bursts !== 16'(exp_rb)) begin
         errors++;
         $display("FAIL abort_recover: got %0d want %0d", rd_bursts, exp_rb);
      end
   endtask

   task automatic test_reset_wd_wait;
      bus_in = 16'h0043;
      wrqst  = 1'b1;
      tick();
      wrqst = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      bus_in = 16'hDEAD;
      wrqst  = 1'b1;
      tick();
      reset  = 1'b0;
      wrqst  = 1'b0;
      bus_in = 16'd0;
      exp_rb = 0;
      exp_wr = 0;
      tick();
      checks++;
      if ({rrdy, rdrdy, wacpt, bus_oe} !== 4'b0 || bus_out !== 16'd0 ||
          rd_bursts !== 16'd0 || wr_count !== 16'd0) begin
         errors++;
         $display("FAIL wd_reset_out: got %b%b%b%b %h %h %h want all 0",
                  rrdy, rdrdy, wacpt, bus_oe, bus_out, rd_bursts, wr_count);
      end
      start_read(16'h0043);
      for (int w = 0; w < 4; w++) recv_word(0);
   endtask

   initial begin
      test_reset();
      test_plain_write();
      test_block_read();
      test_write_miss();
      test_slow_acceptor();
      test_abort();
      test_reset_wd_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
